// File: rtl/slow_tick_timer_if.sv
// slow_tick_timer_if
//   Groups the timer's data-side signals so a controller can hook up to the
//   timer through one port. Clock and reset are not part of the bundle.
//
//   Parameter
//     CountBits  width of Period and Count
//
//   Signals
//     SlowCLK   divided square wave, sampled as data in the master domain
//     Start     level request to begin a period (honoured in IDLE only)
//     Stop      level abort
//     Period    ticks to count, captured when Start is accepted
//     Tick      one-cycle strobe per SlowCLK rising edge
//     Busy      high while the timer is counting
//     Done      one-cycle strobe at terminal count
//     Count     ticks elapsed in the current period
//
//   Modports
//     master  drives SlowCLK/Start/Stop/Period, observes the status outputs
//     slave   the timer itself
interface slow_tick_timer_if #(
  parameter int CountBits = 16
);

  logic                 SlowCLK;
  logic                 Start;
  logic                 Stop;
  logic [CountBits-1:0] Period;
  logic                 Tick;
  logic                 Busy;
  logic                 Done;
  logic [CountBits-1:0] Count;

  modport master (
    output SlowCLK,
    output Start,
    output Stop,
    output Period,
    input  Tick,
    input  Busy,
    input  Done,
    input  Count
  );

  modport slave (
    input  SlowCLK,
    input  Start,
    input  Stop,
    input  Period,
    output Tick,
    output Busy,
    output Done,
    output Count
  );

endinterface

// File: rtl/slow_tick_timer.sv
// slow_tick_timer
//   Samples the divided clock from the frequency generator as ordinary data,
//   turns each of its rising edges into a one-cycle Tick, and counts those
//   ticks against a programmable period. Lets display scan, debounce and
//   UART timeout logic time events without clocking anything off SlowCLK.
//
//   Parameter
//     CountBits  width of Period and Count (max period 2^CountBits-1 ticks)
//
//   Ports
//     InputCLK  master clock, all logic on its rising edge
//     ResetN    synchronous reset, active-low
//     Bus       slow_tick_timer_if.slave: SlowCLK, Start, Stop, Period in;
//               Tick, Busy, Done, Count out (all outputs registered)
//
//   Build option
//     AUTO_RELOAD_EN  when defined, the timer reloads at terminal count and
//                     keeps running (Done pulses alongside the final Tick)
//                     until Stop. When undefined, it is one-shot and passes
//                     through DONE before returning to IDLE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   StIdle  | waiting for Start; Count keeps the last result
//   StRun   | counting ticks toward PeriodReg; Busy high
//   StDone  | one-cycle completion state; Done strobes, then back to idle
module slow_tick_timer #(
  parameter int CountBits = 16
) (
  input logic            InputCLK,
  input logic            ResetN,
  slow_tick_timer_if.slave Bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } stateT;

  stateT                state;
  logic                 slowPrev;
  logic                 tickReg;
  logic                 busyReg;
  logic                 doneReg;
  logic [CountBits-1:0] countReg;
  logic [CountBits-1:0] periodReg;

  logic                 rise;
  logic [CountBits:0]   countNext;
  logic                 terminal;

  // slowPrev resets high so a SlowCLK that is already high when reset
  // releases is not mistaken for a rising edge.
  assign rise = Bus.SlowCLK & ~slowPrev;

  // One extra bit so Count+1 never wraps back onto a small PeriodReg.
  assign countNext = {1'b0, countReg} + {{CountBits{1'b0}}, 1'b1};
  assign terminal  = (countNext == {1'b0, periodReg});

  always_ff @(posedge InputCLK) begin
    if (!ResetN) begin
      state     <= StIdle;
      slowPrev  <= 1'b1;
      tickReg   <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      countReg  <= '0;
      periodReg <= '0;
    end else begin
      slowPrev <= Bus.SlowCLK;
      tickReg  <= rise;
      doneReg  <= 1'b0;

      case (state)
        StIdle: begin
          busyReg <= 1'b0;
          if (Bus.Stop) begin
            countReg <= '0;
          end else if (Bus.Start) begin
            periodReg <= Bus.Period;
            countReg  <= '0;
            if (Bus.Period != '0) begin
              state   <= StRun;
              busyReg <= 1'b1;
            end else begin
              // Zero-length period completes without ever counting.
              state <= StDone;
            end
          end
        end

        StRun: begin
          // Stop beats both a simultaneous tick and a terminal count.
          if (Bus.Stop) begin
            state    <= StIdle;
            busyReg  <= 1'b0;
            countReg <= '0;
          end else if (rise) begin
            if (terminal) begin
`ifdef AUTO_RELOAD_EN
              countReg <= '0;
              doneReg  <= 1'b1;
`else
              countReg <= periodReg;
              state    <= StDone;
              busyReg  <= 1'b0;
`endif
            end else begin
              countReg <= countNext[CountBits-1:0];
            end
          end
        end

        StDone: begin
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= StIdle;
        end

        default: begin
          state   <= StIdle;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign Bus.Tick  = tickReg;
  assign Bus.Busy  = busyReg;
  assign Bus.Done  = doneReg;
  assign Bus.Count = countReg;

endmodule
